// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen: linear FM sweep DDS driving a sine LUT; the sweep runs while En_Iz is high.
// A start command is edge-detected and registered, so ARMED rises two clocks after DDS_start.
module dds_sweep_gen #(
  parameter int FTW_W    = 48,
  parameter int RATE_W   = 32,
  parameter int PHASE_OW = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [FTW_W-1:0]    DDS_freq,
  input  logic [FTW_W-1:0]    DDS_delta_freq,
  input  logic [RATE_W-1:0]   DDS_delta_rate,
  input  logic                DDS_start,
  input  logic                En_Iz,
  output logic [FTW_W-1:0]    FTW,
  output logic [PHASE_OW-1:0] PHASE,
  output logic                SWEEP_ACTIVE,
  output logic                ARMED,
  output logic                SWEEP_DONE,
  output logic                START_IGNORED
);
  typedef enum logic [1:0] {IDLE, ARM, SWEEP} state_t;
  state_t state, state_nx;
  logic start_d, start_q, latch, enter, leave;
  logic [FTW_W-1:0] shadow_freq, shadow_delta, acc;
  logic [RATE_W-1:0] shadow_rate, rate_cnt;
  always_comb begin
    state_nx = state;
    latch = 1'b0;
    enter = 1'b0;
    leave = 1'b0;
    case (state)
      IDLE: begin
        latch = start_q;
        state_nx = start_q ? ARM : IDLE;
      end
      ARM: begin
        latch = start_q;
        enter = !start_q && En_Iz;
        state_nx = enter ? SWEEP : ARM;
      end
      default: begin
        leave = !En_Iz;
        state_nx = leave ? IDLE : SWEEP;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      start_d <= 1'b0;
      start_q <= 1'b0;
      shadow_freq <= '0;
      shadow_delta <= '0;
      shadow_rate <= '0;
      rate_cnt <= '0;
      FTW <= '0;
      acc <= '0;
      SWEEP_DONE <= 1'b0;
      START_IGNORED <= 1'b0;
    end else begin
      state <= state_nx;
      start_d <= DDS_start;
      start_q <= DDS_start & ~start_d;
      SWEEP_DONE <= leave;
      START_IGNORED <= (state == SWEEP) && start_q;
      if (latch) begin
        shadow_freq <= DDS_freq;
        shadow_delta <= DDS_delta_freq;
        shadow_rate <= DDS_delta_rate;
      end
      if (enter) begin
        FTW <= shadow_freq;
        rate_cnt <= shadow_rate;
        acc <= '0;
      end else if (leave) begin
        FTW <= '0;
        acc <= '0;
      end else if (state == SWEEP) begin
        acc <= acc + FTW;
        FTW <= (rate_cnt == '0) ? FTW + shadow_delta : FTW;
        rate_cnt <= (rate_cnt == '0) ? shadow_rate : rate_cnt - 1'b1;
      end
    end
  end
  assign PHASE = acc[FTW_W-1 -: PHASE_OW];
  assign SWEEP_ACTIVE = (state == SWEEP);
  assign ARMED = (state == ARM);
endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb_dds_sweep_gen: directed sweeps checked every cycle against a closed-form sweep model,
// plus literal FTW/PHASE/flag values worked out by hand.
module tb_dds_sweep_gen;
  logic CLK = 1'b0;
  logic RESET_N;
  logic [47:0] DDS_freq = '0, DDS_delta_freq = '0;
  logic [31:0] DDS_delta_rate = '0;
  logic DDS_start = 1'b0, En_Iz = 1'b0;
  logic [47:0] FTW;
  logic [15:0] PHASE;
  logic SWEEP_ACTIVE, ARMED, SWEEP_DONE, START_IGNORED;
  int n_chk = 0, n_fail = 0;
  bit run = 1'b0;

  dds_sweep_gen dut (
    .CLK(CLK), .RESET_N(RESET_N), .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq),
    .DDS_delta_rate(DDS_delta_rate), .DDS_start(DDS_start), .En_Iz(En_Iz), .FTW(FTW),
    .PHASE(PHASE), .SWEEP_ACTIVE(SWEEP_ACTIVE), .ARMED(ARMED), .SWEEP_DONE(SWEEP_DONE),
    .START_IGNORED(START_IGNORED)
  );

  always #5 CLK = ~CLK;

  // model: mode 0 idle, 1 armed, 2 sweeping; k counts cycles since sweep entry
  int m_mode = 0;
  bit m_sd = 0, m_eq = 0, m_done = 0, m_ign = 0;
  logic [47:0] m_f = '0, m_d = '0, m_acc = '0;
  logic [31:0] m_r = '0;
  longint unsigned m_k = 0;

  function automatic logic [47:0] mftw();
    logic [63:0] t;
    t = m_f + m_d * (m_k / (longint'(m_r) + 1));
    return (m_mode == 2) ? t[47:0] : 48'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    bit e;
    @(posedge CLK or negedge RESET_N);
    if (!RESET_N) begin
      m_mode = 0; m_sd = 0; m_eq = 0; m_done = 0; m_ign = 0;
      m_f = '0; m_d = '0; m_r = '0; m_acc = '0; m_k = 0;
    end else begin
      e = m_eq;
      m_eq = DDS_start & ~m_sd;
      m_sd = DDS_start;
      m_done = 0;
      m_ign = 0;
      if (m_mode != 2 && e) begin
        m_f = DDS_freq; m_d = DDS_delta_freq; m_r = DDS_delta_rate; m_mode = 1;
      end else if (m_mode == 1 && En_Iz) begin
        m_mode = 2; m_k = 0; m_acc = '0;
      end else if (m_mode == 2) begin
        m_ign = e;
        if (!En_Iz) begin
          m_mode = 0; m_done = 1; m_acc = '0;
        end else begin
          m_acc = m_acc + mftw();
          m_k++;
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (run) begin
      chk("ftw", FTW, mftw());
      chk("phase", PHASE, m_acc[47:32]);
      chk("sweep_active", SWEEP_ACTIVE, m_mode == 2);
      chk("armed", ARMED, m_mode == 1);
      chk("sweep_done", SWEEP_DONE, m_done);
      chk("start_ignored", START_IGNORED, m_ign);
    end
  end

  task automatic arm(input logic [47:0] f, input logic [47:0] d, input logic [31:0] r);
    @(negedge CLK);
    DDS_freq = f; DDS_delta_freq = d; DDS_delta_rate = r; DDS_start = 1'b1;
    @(negedge CLK);
    DDS_start = 1'b0;
    @(negedge CLK);
  endtask

  task automatic stop();
    En_Iz = 1'b0;
    @(negedge CLK);
    chk("done_pulse", SWEEP_DONE, 1);
    chk("ftw_after_done", FTW, 0);
    @(negedge CLK);
  endtask

  initial begin
    logic [47:0] t3 [5];
    t3 = '{48'h100, 48'h100, 48'hFF, 48'hFF, 48'hFE};
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    run = 1'b1;
    chk("rst_ftw", FTW, 0);
    chk("rst_flags", {SWEEP_ACTIVE, ARMED, SWEEP_DONE, START_IGNORED}, 0);
    RESET_N = 1'b1;
    // 1: basic up-ramp, step every 4 cycles
    arm(48'h1000, 48'h10, 3);
    chk("t1_armed", ARMED, 1);
    En_Iz = 1'b1;
    @(negedge CLK);
    chk("t1_ftw0", FTW, 48'h1000);
    repeat (3) @(negedge CLK);
    chk("t1_ftw0_hold", FTW, 48'h1000);
    @(negedge CLK);
    chk("t1_ftw1", FTW, 48'h1010);
    repeat (4) @(negedge CLK);
    chk("t1_ftw2", FTW, 48'h1020);
    repeat (9) @(negedge CLK);
    stop();
    // 2: wrap of FTW and accumulator
    arm(48'hFFFF_FFFF_FFF0, 48'h20, 0);
    En_Iz = 1'b1;
    @(negedge CLK);
    chk("t2_ftw0", FTW, 48'hFFFF_FFFF_FFF0);
    chk("t2_ph0", PHASE, 16'h0);
    @(negedge CLK);
    chk("t2_ftw_wrap", FTW, 48'h10);
    chk("t2_ph1", PHASE, 16'hFFFF);
    @(negedge CLK);
    chk("t2_ftw2", FTW, 48'h30);
    chk("t2_ph_wrap", PHASE, 16'h0);
    repeat (5) @(negedge CLK);
    stop();
    // 3: down-chirp
    arm(48'h100, 48'hFFFF_FFFF_FFFF, 1);
    En_Iz = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("t3_ftw%0d", i), FTW, t3[i]);
    end
    stop();
    // 4: start edge during sweep is dropped
    arm(48'h1000, 48'h10, 3);
    En_Iz = 1'b1;
    repeat (2) @(negedge CLK);
    DDS_freq = 48'h5000; DDS_start = 1'b1;
    @(negedge CLK);
    DDS_start = 1'b0;
    chk("t4_no_ign_yet", START_IGNORED, 0);
    @(negedge CLK);
    chk("t4_ign", START_IGNORED, 1);
    chk("t4_ftw", FTW, 48'h1000);
    @(negedge CLK);
    chk("t4_ign_clear", START_IGNORED, 0);
    chk("t4_ftw_step", FTW, 48'h1010);
    stop();
    arm(48'h6000, 48'h1, 0);
    En_Iz = 1'b1;
    @(negedge CLK);
    chk("t4_new_sweep", FTW, 48'h6000);
    repeat (3) @(negedge CLK);
    stop();
    // 5: last command in ARM wins
    arm(48'h200, 48'h1, 0);
    arm(48'h300, 48'h1, 0);
    En_Iz = 1'b1;
    @(negedge CLK);
    chk("t5_ftw", FTW, 48'h300);
    repeat (3) @(negedge CLK);
    stop();
    // 6: async reset mid-sweep
    arm(48'h1000, 48'h10, 0);
    En_Iz = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6_ftw", FTW, 0);
    chk("t6_phase", PHASE, 0);
    chk("t6_flags", {SWEEP_ACTIVE, ARMED, SWEEP_DONE, START_IGNORED}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("t6_no_restart", {SWEEP_ACTIVE, ARMED}, 0);
    En_Iz = 1'b0;
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
